// File: rtl/x2050mpxcu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | x2050mpxcu - byte-mode control unit answering on the 2050 mpx bus    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module x2050mpxcu #(
    parameter logic [7:0] DEV_ADDR = 8'h0A,
    parameter int         DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [8:0] i_mpx_bus_out,
    input  logic       i_mpx_operational_out,
    input  logic       i_mpx_select_out,
    input  logic       i_mpx_hold_out,
    input  logic       i_mpx_address_out,
    input  logic       i_mpx_command_out,
    input  logic       i_mpx_service_out,
    input  logic       i_mpx_suppress_out,
    output logic [8:0] o_mpx_bus_in,
    output logic       o_mpx_operational_in,
    output logic       o_mpx_select_in,
    output logic       o_mpx_address_in,
    output logic       o_mpx_status_in,
    output logic       o_mpx_service_in,
    output logic       o_mpx_request_in,
    output logic [7:0] o_sense,
    output logic [3:0] o_state
);

    localparam int              c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_iw    = c_aw + 1;
    localparam logic [c_iw-1:0] c_depth = c_iw'(DEPTH);

    localparam logic [7:0] c_cmd_write = 8'h01;
    localparam logic [7:0] c_cmd_read  = 8'h02;
    localparam logic [7:0] c_cmd_noop  = 8'h03;
    localparam logic [7:0] c_cmd_sense = 8'h04;
    localparam logic [7:0] c_sts_uc    = 8'h02;
    localparam logic [7:0] c_sts_cede  = 8'h0C;
    localparam logic [7:0] c_sts_cedeu = 8'h0E;
    localparam logic [7:0] c_sns_rej   = 8'h80;
    localparam logic [7:0] c_sns_bochk = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PASS    = 4'd1,
        S_ADR     = 4'd2,
        S_CMDDROP = 4'd3,
        S_ISTS    = 4'd4,
        S_ISDROP  = 4'd5,
        S_DATA    = 4'd6,
        S_DDROP   = 4'd7,
        S_ESTS    = 4'd8,
        S_EDROP   = 4'd9
    } state_t;

    state_t          state_q;
    logic [8:0]      bus_in_q;
    logic            op_in_q, sel_in_q, adr_in_q, sts_in_q, svc_in_q;
    logic [7:0]      sense_q;
    logic [7:0]      cmd_q;
    logic            cmd_par_ok_q;
    logic [7:0]      status_q;
    logic            uc_q, stop_q, stack_q;
    logic [c_iw-1:0] count_q;
    logic [c_iw-1:0] idx_q;
    logic [7:0]      mem_q [DEPTH];

    logic [7:0]      xfer_byte;
    logic [c_iw-1:0] xfer_limit;
    logic [7:0]      end_status;
    logic            addr_hit;
    logic            mem_we;
    logic            unused_hold;

    function automatic logic [8:0] f_odd_par(input logic [7:0] b);
        return {~^b, b};
    endfunction

    assign addr_hit    = (i_mpx_bus_out[7:0] == DEV_ADDR) && (^i_mpx_bus_out);
    assign end_status  = uc_q ? c_sts_cedeu : c_sts_cede;
    assign unused_hold = i_mpx_hold_out;
    assign mem_we      = i_mpx_operational_out && (state_q == S_DATA) &&
                         i_mpx_service_out && (cmd_q == c_cmd_write);

    always_comb begin
        xfer_byte  = 8'h00;
        xfer_limit = c_depth;
        if (cmd_q == c_cmd_read) begin
            xfer_byte  = mem_q[idx_q[c_aw-1:0]];
            xfer_limit = count_q;
        end else if (cmd_q == c_cmd_sense) begin
            xfer_byte  = sense_q;
            xfer_limit = c_iw'(1);
        end
    end

    // Buffer has no reset: contents survive both reset and interface drops.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[idx_q[c_aw-1:0]] <= i_mpx_bus_out[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            bus_in_q     <= '0;
            op_in_q      <= 1'b0;
            sel_in_q     <= 1'b0;
            adr_in_q     <= 1'b0;
            sts_in_q     <= 1'b0;
            svc_in_q     <= 1'b0;
            sense_q      <= '0;
            cmd_q        <= '0;
            cmd_par_ok_q <= 1'b0;
            status_q     <= '0;
            uc_q         <= 1'b0;
            stop_q       <= 1'b0;
            stack_q      <= 1'b0;
            count_q      <= '0;
            idx_q        <= '0;
        end else if (!i_mpx_operational_out) begin
            state_q  <= S_IDLE;
            bus_in_q <= '0;
            op_in_q  <= 1'b0;
            sel_in_q <= 1'b0;
            adr_in_q <= 1'b0;
            sts_in_q <= 1'b0;
            svc_in_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_mpx_address_out && i_mpx_select_out) begin
                        if (addr_hit) begin
                            op_in_q  <= 1'b1;
                            adr_in_q <= 1'b1;
                            bus_in_q <= f_odd_par(DEV_ADDR);
                            state_q  <= S_ADR;
                        end else begin
                            sel_in_q <= 1'b1;
                            state_q  <= S_PASS;
                        end
                    end
                end
                S_PASS: begin
                    if (!i_mpx_select_out) begin
                        sel_in_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_ADR: begin
                    if (!i_mpx_address_out && i_mpx_command_out) begin
                        cmd_q        <= i_mpx_bus_out[7:0];
                        cmd_par_ok_q <= ^i_mpx_bus_out;
                        adr_in_q     <= 1'b0;
                        bus_in_q     <= '0;
                        state_q      <= S_CMDDROP;
                    end
                end
                S_CMDDROP: begin
                    if (!i_mpx_command_out) begin
                        uc_q     <= 1'b0;
                        stop_q   <= 1'b0;
                        stack_q  <= 1'b0;
                        idx_q    <= '0;
                        sts_in_q <= 1'b1;
                        state_q  <= S_ISTS;
                        if (!cmd_par_ok_q) begin
                            sense_q  <= c_sns_bochk;
                            status_q <= c_sts_uc;
                            bus_in_q <= f_odd_par(c_sts_uc);
                        end else if (cmd_q inside {c_cmd_write, c_cmd_read, c_cmd_noop, c_cmd_sense}) begin
                            status_q <= 8'h00;
                            bus_in_q <= f_odd_par(8'h00);
                            if (cmd_q != c_cmd_sense) begin
                                sense_q <= '0;
                            end
                        end else begin
                            sense_q  <= c_sns_rej;
                            status_q <= c_sts_uc;
                            bus_in_q <= f_odd_par(c_sts_uc);
                        end
                    end
                end
                S_ISTS: begin
                    // Command-out here is a stack: the operation ends with no data.
                    if (i_mpx_service_out || i_mpx_command_out) begin
                        sts_in_q <= 1'b0;
                        bus_in_q <= '0;
                        stack_q  <= ~i_mpx_service_out;
                        state_q  <= S_ISDROP;
                    end
                end
                S_ISDROP: begin
                    if (!i_mpx_service_out && !i_mpx_command_out) begin
                        if ((status_q != 8'h00) || (cmd_q == c_cmd_noop)) begin
                            op_in_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (stack_q || ((cmd_q == c_cmd_read) && (count_q == '0))) begin
                            state_q <= S_ESTS;
                            if (!i_mpx_suppress_out) begin
                                sts_in_q <= 1'b1;
                                bus_in_q <= f_odd_par(end_status);
                            end
                        end else begin
                            svc_in_q <= 1'b1;
                            bus_in_q <= f_odd_par(xfer_byte);
                            state_q  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (i_mpx_service_out) begin
                        if ((cmd_q == c_cmd_write) && !(^i_mpx_bus_out)) begin
                            sense_q <= c_sns_bochk;
                            uc_q    <= 1'b1;
                        end
                        idx_q    <= idx_q + c_iw'(1);
                        svc_in_q <= 1'b0;
                        bus_in_q <= '0;
                        state_q  <= S_DDROP;
                    end else if (i_mpx_command_out) begin
                        stop_q   <= 1'b1;
                        svc_in_q <= 1'b0;
                        bus_in_q <= '0;
                        state_q  <= S_DDROP;
                    end
                end
                S_DDROP: begin
                    if (!i_mpx_service_out && !i_mpx_command_out) begin
                        if (stop_q || (idx_q == xfer_limit)) begin
                            if (cmd_q == c_cmd_write) begin
                                count_q <= idx_q;
                            end
                            state_q <= S_ESTS;
                            if (!i_mpx_suppress_out) begin
                                sts_in_q <= 1'b1;
                                bus_in_q <= f_odd_par(end_status);
                            end
                        end else begin
                            svc_in_q <= 1'b1;
                            bus_in_q <= f_odd_par(xfer_byte);
                            state_q  <= S_DATA;
                        end
                    end
                end
                S_ESTS: begin
                    if (!sts_in_q) begin
                        if (!i_mpx_suppress_out) begin
                            sts_in_q <= 1'b1;
                            bus_in_q <= f_odd_par(end_status);
                        end
                    end else if (i_mpx_service_out) begin
                        sts_in_q <= 1'b0;
                        bus_in_q <= '0;
                        state_q  <= S_EDROP;
                    end
                end
                S_EDROP: begin
                    if (!i_mpx_service_out) begin
                        op_in_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_mpx_bus_in         = bus_in_q;
    assign o_mpx_operational_in = op_in_q;
    assign o_mpx_select_in      = sel_in_q;
    assign o_mpx_address_in     = adr_in_q;
    assign o_mpx_status_in      = sts_in_q;
    assign o_mpx_service_in     = svc_in_q;
    assign o_mpx_request_in     = 1'b0;
    assign o_sense              = sense_q;
    assign o_state              = state_q;

endmodule
`default_nettype wire

// File: tb/tb_x2050mpxcu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_x2050mpxcu - channel-side driver against a byte-level device model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_x2050mpxcu;
    localparam logic [7:0] DEV_ADDR = 8'h0A;
    localparam int         DEPTH    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] bus_out;
    logic       op_out, sel_out, hold_out, adr_out, cmd_out, svc_out, sup_out;
    logic [8:0] bus_in;
    logic       op_in, sel_in, adr_in, sts_in, svc_in, req_in;
    logic [7:0] sense;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    // Device model: buffer contents, byte count of last write, sense byte.
    logic [7:0] m_mem [DEPTH];
    int         m_count;
    logic [7:0] m_sense;
    logic [7:0] wdat [DEPTH];
    bit         wbad [DEPTH];

    always #5 clk = ~clk;

    x2050mpxcu #(.DEV_ADDR(DEV_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_mpx_bus_out         (bus_out),
        .i_mpx_operational_out (op_out),
        .i_mpx_select_out      (sel_out),
        .i_mpx_hold_out        (hold_out),
        .i_mpx_address_out     (adr_out),
        .i_mpx_command_out     (cmd_out),
        .i_mpx_service_out     (svc_out),
        .i_mpx_suppress_out    (sup_out),
        .o_mpx_bus_in          (bus_in),
        .o_mpx_operational_in  (op_in),
        .o_mpx_select_in       (sel_in),
        .o_mpx_address_in      (adr_in),
        .o_mpx_status_in       (sts_in),
        .o_mpx_service_in      (svc_in),
        .o_mpx_request_in      (req_in),
        .o_sense               (sense),
        .o_state               (state)
    );

    function automatic logic [8:0] par9(input logic [7:0] b);
        return {~^b, b};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One complete channel-initiated operation; abort drops operational-out
    // at the first data byte.
    task automatic do_op(input logic [7:0] cmd, input bit cmd_bad, input int nw, input bit abort);
        logic [7:0] ist;
        logic [7:0] exp_q [$];
        bit         is_write, uc, stop, sup;
        int         nb;
        int         k;
        ist = 8'h00; uc = 1'b0; stop = 1'b0; is_write = 1'b0; nb = 0;
        exp_q = {};
        if (cmd_bad) begin
            ist = 8'h02; m_sense = 8'h20;
        end else if (cmd >= 8'h01 && cmd <= 8'h04) begin
            if (cmd != 8'h04) m_sense = 8'h00;
        end else begin
            ist = 8'h02; m_sense = 8'h80;
        end
        if (ist == 8'h00) begin
            case (cmd)
                8'h01: begin is_write = 1'b1; nb = nw; stop = (nw < DEPTH); end
                8'h02: for (int i = 0; i < m_count; i++) exp_q.push_back(m_mem[i]);
                8'h04: exp_q.push_back(m_sense);
                default: ;
            endcase
            if (!is_write) nb = exp_q.size();
        end
        sup = 1'($urandom_range(0, 1));
        sup_out = sup;

        bus_out = par9(DEV_ADDR); sel_out = 1'b1; hold_out = 1'b1; adr_out = 1'b1;
        step();
        chk("sel_opin", op_in, 1);
        chk("sel_adrin", adr_in, 1);
        chk("sel_bus", bus_in, par9(DEV_ADDR));
        adr_out = 1'b0; cmd_out = 1'b1;
        bus_out = par9(cmd);
        if (cmd_bad) bus_out[8] = ~bus_out[8];
        step();
        chk("cmd_adrin_drop", adr_in, 0);
        cmd_out = 1'b0; bus_out = '0;
        step();
        chk("ists_tag", sts_in, 1);
        chk("ists_byte", bus_in, par9(ist));
        svc_out = 1'b1;
        step();
        chk("ists_drop", sts_in, 0);
        svc_out = 1'b0;
        step();
        if (ist != 8'h00 || cmd == 8'h03) begin
            chk("nodata_opin_drop", op_in, 0);
        end else begin
            for (int i = 0; i < nb; i++) begin
                chk("data_svcin", svc_in, 1);
                if (!is_write) chk("data_byte", bus_in, par9(exp_q[i]));
                if (abort) begin
                    op_out = 1'b0;
                    step();
                    chk("abort_tags", {3'b000, op_in, sel_in, adr_in, sts_in, svc_in, req_in}, 0);
                    chk("abort_bus", bus_in, 0);
                    chk("abort_state", state, 0);
                    op_out = 1'b1; sup_out = 1'b0; sel_out = 1'b0; hold_out = 1'b0;
                    step();
                    return;
                end
                if (is_write) begin
                    bus_out = par9(wdat[i]);
                    if (wbad[i]) begin
                        bus_out[8] = ~bus_out[8];
                        uc = 1'b1;
                        m_sense = 8'h20;
                    end
                    m_mem[i] = wdat[i];
                end
                svc_out = 1'b1;
                step();
                chk("data_svc_drop", svc_in, 0);
                svc_out = 1'b0; bus_out = '0;
                step();
            end
            if (stop) begin
                chk("stop_svcin", svc_in, 1);
                cmd_out = 1'b1;
                step();
                chk("stop_svc_drop", svc_in, 0);
                cmd_out = 1'b0;
                step();
            end
            if (is_write) m_count = nb;
            if (sup) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    chk("suppress_hold", sts_in, 0);
                    if (j == k - 1) sup_out = 1'b0;
                    step();
                end
            end
            chk("ests_tag", sts_in, 1);
            chk("ests_byte", bus_in, par9(uc ? 8'h0E : 8'h0C));
            svc_out = 1'b1;
            step();
            chk("ests_drop", sts_in, 0);
            svc_out = 1'b0;
            step();
            chk("end_opin_drop", op_in, 0);
        end
        chk("sense_out", sense, m_sense);
        chk("req_in", req_in, 0);
        sel_out = 1'b0; hold_out = 1'b0; sup_out = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] c;
        int         r;
        int         n;
        bit         bad;
        rst_n = 1'b0; op_out = 1'b0; sel_out = 1'b0; hold_out = 1'b0; adr_out = 1'b0;
        cmd_out = 1'b0; svc_out = 1'b0; sup_out = 1'b0; bus_out = '0;
        m_count = 0; m_sense = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; wdat[i] = 8'h00; wbad[i] = 1'b0; end
        repeat (2) step();
        chk("rst_bus", bus_in, 0);
        chk("rst_tags", {3'b000, op_in, sel_in, adr_in, sts_in, svc_in, req_in}, 0);
        chk("rst_sense", sense, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1; op_out = 1'b1;
        step();

        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        do_op(8'h01, 1'b0, 3, 1'b0);
        do_op(8'h02, 1'b0, 0, 1'b0);

        // Address for another device: pass select through.
        bus_out = par9(8'h0B); sel_out = 1'b1; hold_out = 1'b1; adr_out = 1'b1;
        step();
        chk("pass_selin", sel_in, 1);
        chk("pass_opin", op_in, 0);
        adr_out = 1'b0;
        step();
        chk("pass_hold", sel_in, 1);
        sel_out = 1'b0; hold_out = 1'b0; bus_out = '0;
        step();
        chk("pass_drop", sel_in, 0);

        do_op(8'h07, 1'b0, 0, 1'b0);
        do_op(8'h04, 1'b0, 0, 1'b0);

        wdat[0] = 8'h5A; wdat[1] = 8'hA5; wbad[1] = 1'b1;
        do_op(8'h01, 1'b0, 2, 1'b0);
        wbad[1] = 1'b0;
        do_op(8'h02, 1'b1, 0, 1'b0);
        do_op(8'h03, 1'b0, 0, 1'b0);

        for (int i = 0; i < DEPTH; i++) wdat[i] = 8'($urandom);
        do_op(8'h01, 1'b0, DEPTH, 1'b0);
        do_op(8'h02, 1'b0, 0, 1'b0);

        repeat (14) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 5: c = 8'h01;
                1: c = 8'h02;
                2: c = 8'h04;
                3: c = 8'h03;
                default: begin
                    c = 8'($urandom);
                    while (c >= 8'h01 && c <= 8'h04) c = 8'($urandom);
                end
            endcase
            bad = ($urandom_range(0, 9) == 0);
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                wdat[i] = 8'($urandom);
                wbad[i] = ($urandom_range(0, 15) == 0);
            end
            do_op(c, bad, n, 1'b0);
        end

        for (int i = 0; i < DEPTH; i++) wbad[i] = 1'b0;
        do_op(8'h01, 1'b0, 4, 1'b0);
        do_op(8'h02, 1'b0, 0, 1'b1);
        do_op(8'h02, 1'b0, 0, 1'b0);

        // Asynchronous reset while address-in is up.
        bus_out = par9(DEV_ADDR); sel_out = 1'b1; hold_out = 1'b1; adr_out = 1'b1;
        step();
        chk("adr_before_rst", adr_in, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tags", {3'b000, op_in, sel_in, adr_in, sts_in, svc_in, req_in}, 0);
        chk("arst_bus", bus_in, 0);
        chk("arst_state", state, 0);
        chk("arst_sense", sense, 0);
        sel_out = 1'b0; hold_out = 1'b0; adr_out = 1'b0; bus_out = '0;
        m_count = 0; m_sense = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        do_op(8'h02, 1'b0, 0, 1'b0);
        do_op(8'h04, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/x2050mpxcu.md
Name: x2050mpxcu

Overview:
- Control-unit (device) end of the 2050 multiplexor bus-and-tag interface: the responder that the channel's select/address/command/service/suppress-out tags talk to.
- Emulates one byte-mode device with a small data buffer. Supports write, read, sense and no-op commands, initial status, data transfer and ending status.
- Used as the bench/peripheral partner of the channel in system simulation.

Parameters:
- DEV_ADDR, 8'h0A, device address this CU answers to (bus bits 0-7).
- DEPTH, 16, data buffer size in bytes (power of 2, max 256).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_mpx_bus_out  in  9  channel bus out. Index 8 = parity P. Index 7-n = bit n.
- i_mpx_operational_out, i_mpx_select_out, i_mpx_hold_out, i_mpx_address_out, i_mpx_command_out, i_mpx_service_out, i_mpx_suppress_out  in  1 each  outbound tags.
- o_mpx_bus_in  out  9  bus in, same layout as bus out.
- o_mpx_operational_in, o_mpx_select_in, o_mpx_address_in, o_mpx_status_in, o_mpx_service_in, o_mpx_request_in  out  1 each  inbound tags.
- o_sense  out  8  current sense byte.
- o_state  out  4  FSM state encoding, for debug.

Behaviour:
- Reset (async, active-low): all tags 0, bus_in 0, sense 0, count 0, state IDLE.
- Registered response: all outputs registered. Every response appears exactly 1 clock after the input sample that causes it.
- Parity: bus_in[8] = odd parity over bus_in[7:0]. A bus_out byte is good when its 9 bits have odd weight.
- Status byte encoding (bit n at index 7-n): CE+DE = 8'h0C; CE+DE+UC = 8'h0E; busy = 8'h10.
- Sense encoding: command reject = 8'h80; bus-out check = 8'h20.
- request_in is always 0.
- Operational_out low in any state: drop all tags the next clock and go to IDLE. Buffer, count and sense are retained.
- IDLE, with address_out & select_out high:
  - bus_out = DEV_ADDR with good parity: raise operational_in, go ADR.
  - otherwise: raise select_in, go PASS.
- PASS: hold select_in until select_out is low, then return to IDLE.
- ADR: raise address_in with bus_in = DEV_ADDR. Wait for address_out low and then command_out high.
  - Latch the command byte from bus_out when command_out rises.
  - Drop address_in, go CMDDROP.
- CMDDROP: wait for command_out low. Decode the command, then go ISTS.
  - Bad command parity: sense = 8'h20, status 8'h02 (UC), end after initial status.
  - 8'h01 write, 8'h02 read, 8'h04 sense, 8'h03 no-op: initial status 8'h00. Any new command other than sense clears sense.
  - Any other byte: sense = 8'h80, status 8'h02, end after initial status.
- ISTS: raise status_in with the status byte.
  - service_out high: drop status_in, go ISDROP.
  - command_out high (stack): drop status_in, go ISDROP, and mark the operation finished without data.
- ISDROP: wait for service_out and command_out both low.
  - Status was non-zero, or the command is no-op: drop operational_in, go IDLE.
  - Otherwise: go DATA with index = 0.
- DATA: raise service_in.
  - Read: bus_in = buf[index].
  - Sense: bus_in = sense.
  - Write: bus_in = 0.
  - On service_out: for write, store bus_out[7:0] in buf[index]; a parity error sets sense 8'h20 and UC. Then index++.
  - On command_out (stop): transfer ends, index is not advanced.
  - In both cases drop service_in and go DDROP.
- DDROP: wait for service_out and command_out low.
  - Go ESTS if stop was seen, or index reached the limit. Limits: write DEPTH, read count, sense 1.
  - Otherwise go back to DATA.
  - Read with count 0: go straight to ESTS without a service_in.
- Write completion: count = index at the end of the write.
- ESTS: hold off while suppress_out is high. Then raise status_in with 8'h0C, or 8'h0E if UC.
  - On service_out: drop status_in, go EDROP.
- EDROP: wait for service_out low. Drop operational_in, go IDLE.
- Unused inputs: select_out falling mid-operation is ignored (hold_out semantics). A tag already high on entry to a state is taken as an edge.

Test Plan:
- Write then read: bus_out 8'h0A+P selection, cmd 8'h01, send 3 bytes (8'h11, 8'h22, 8'h33), then command_out stop -> initial status 00, three service_in cycles, ending 8'h0C. Then cmd 8'h02 -> bus_in returns 11, 22, 33 with odd parity, ending 8'h0C.
- Address 8'h0B while DEV_ADDR = 8'h0A -> select_in high within 1 clock, operational_in stays 0, select_in drops 1 clock after select_out falls.
- Invalid cmd 8'h07 -> initial status 8'h02, operational_in drops after service_out; following sense cmd 8'h04 -> one data byte 8'h80, ending 8'h0C.
- Write byte with bad parity -> ending status 8'h0E, o_sense = 8'h20.
- Operational_out dropped in DATA -> all inbound tags 0 on next clock, o_state = IDLE.
- Async reset asserted mid-ADR -> all outputs 0 immediately, without waiting for a clock edge.
